// File: rtl/compactor_pkg.sv
// Shared types and constants for the output signature compactor.
package compactor_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C1_1DB7;
  localparam int unsigned COUNT_WIDTH  = 16;

endpackage

// File: rtl/signature_shifter.sv
// Snapshot register and serial readout FSM: captures LEN bits on request
// and streams them MSB first, one bit per cycle.
module signature_shifter
  import compactor_pkg::*;
#(
  parameter int unsigned LEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           snap_req,
  input  logic [LEN-1:0] snap_data,
  output logic           busy,
  output logic           sig_out_bit,
  output logic           sig_out_valid,
  output logic           sig_out_last
);

  localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST_CNT     = CW'(LEN - 1);
  localparam logic [CW-1:0] PRE_LAST_CNT = CW'(LEN - 2);

  state_t         state;
  logic [LEN-1:0] shadow;
  logic [CW-1:0]  bitcnt;

  // Shadow shifts in zeros, so after LEN shifts it is empty and the serial
  // bit returns to 0 without extra gating.
  assign sig_out_bit   = shadow[LEN-1];
  assign sig_out_valid = busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shadow       <= '0;
      bitcnt       <= '0;
      busy         <= 1'b0;
      sig_out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snap_req) begin
            shadow       <= snap_data;
            bitcnt       <= '0;
            state        <= SHIFT;
            busy         <= 1'b1;
            sig_out_last <= (LEN == 1);
          end
        end
        SHIFT: begin
          shadow <= shadow << 1;
          if (bitcnt == LAST_CNT) begin
            bitcnt       <= '0;
            state        <= IDLE;
            busy         <= 1'b0;
            sig_out_last <= 1'b0;
          end else begin
            bitcnt       <= bitcnt + 1'b1;
            sig_out_last <= (bitcnt == PRE_LAST_CNT);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/output_signature_compactor.sv
// MISR compactor for unused DUT outputs with serial readout and live parity.
// Define COMPACTOR_CAPTURE_COUNT_EN to append a 16-bit valid count to the stream.
module output_signature_compactor
  import compactor_pkg::*;
#(
  parameter int unsigned           WIDTH     = 64,
  parameter int unsigned           SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0]  POLY      = SIG_WIDTH'(DEFAULT_POLY),
  parameter logic [SIG_WIDTH-1:0]  SEED      = SIG_WIDTH'(32'h0000_0001)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic             snap_req,
  output logic             busy,
  output logic             sig_out_bit,
  output logic             sig_out_valid,
  output logic             sig_out_last,
  output logic             sig_parity
);

  localparam int unsigned NCHUNK = (WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int unsigned PAD_W  = NCHUNK * SIG_WIDTH;
`ifdef COMPACTOR_CAPTURE_COUNT_EN
  localparam int unsigned LEN = SIG_WIDTH + COUNT_WIDTH;
`else
  localparam int unsigned LEN = SIG_WIDTH;
`endif

  logic [PAD_W-1:0]     padded;
  logic [SIG_WIDTH-1:0] fold;
  logic [SIG_WIDTH-1:0] step;
  logic [SIG_WIDTH-1:0] sig;
  logic [LEN-1:0]       snap_data;

  assign padded = PAD_W'(data_in);

  always_comb begin
    fold = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      fold = fold ^ padded[i*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  always_comb begin
    step = {sig[SIG_WIDTH-2:0], 1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig <= SEED;
    end else if (data_valid) begin
      sig <= step ^ fold;
    end
  end

  assign sig_parity = ^sig;

`ifdef COMPACTOR_CAPTURE_COUNT_EN
  logic [COUNT_WIDTH-1:0] valid_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_count <= '0;
    end else if (data_valid && (valid_count != '1)) begin
      valid_count <= valid_count + 1'b1;
    end
  end

  assign snap_data = {sig, valid_count};
`else
  assign snap_data = sig;
`endif

  signature_shifter #(
    .LEN(LEN)
  ) u_shifter (
    .clk          (clk),
    .reset        (reset),
    .snap_req     (snap_req),
    .snap_data    (snap_data),
    .busy         (busy),
    .sig_out_bit  (sig_out_bit),
    .sig_out_valid(sig_out_valid),
    .sig_out_last (sig_out_last)
  );

endmodule

// File: tb/tb_output_signature_compactor.sv
// Directed self-checking bench for output_signature_compactor.
module tb_output_signature_compactor;

`ifdef COMPACTOR_CAPTURE_COUNT_EN
  localparam int LEN = 48;
  localparam logic [47:0] EXP_S1 = {32'hA5A5_0001, 16'h0004};
  localparam logic [47:0] EXP_S3 = {32'h0000_0020, 16'h0005};
`else
  localparam int LEN = 32;
  localparam logic [47:0] EXP_S1 = {16'h0000, 32'hA5A5_0001};
  localparam logic [47:0] EXP_S3 = {16'h0000, 32'h0000_0020};
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] data_in;
  logic        data_valid;
  logic        snap_req;
  logic        busy;
  logic        sig_out_bit;
  logic        sig_out_valid;
  logic        sig_out_last;
  logic        sig_parity;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_sig;

  output_signature_compactor dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .snap_req     (snap_req),
    .busy         (busy),
    .sig_out_bit  (sig_out_bit),
    .sig_out_valid(sig_out_valid),
    .sig_out_last (sig_out_last),
    .sig_parity   (sig_parity)
  );

  always #5 clk = ~clk;

  // Signature step with an all-zero input bus.
  function automatic logic [31:0] misr_zero(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0000_0000);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic dv;
    dv = data_valid;
    @(posedge clk);
    #1;
    if (dv) model_sig = misr_zero(model_sig);
  endtask

  task automatic read_stream(input string tag, input logic [47:0] exp,
                             input bit snap_mid, input bit snap_last);
    for (int i = 0; i < LEN; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), sig_out_valid, 1);
      chk($sformatf("%s_busy%0d", tag, i), busy, 1);
      chk($sformatf("%s_bit%0d", tag, i), sig_out_bit, exp[LEN-1-i]);
      chk($sformatf("%s_last%0d", tag, i), sig_out_last, (i == LEN - 1));
      snap_req = (snap_mid && i == 10) || (snap_last && i == LEN - 1);
      tick();
      snap_req = 1'b0;
    end
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    snap_req   = 1'b0;
    model_sig  = '0;
    #12;
    chk("rst_sig", dut.sig, 32'h0000_0001);
    chk("rst_parity", sig_parity, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", sig_out_valid, 0);
    chk("rst_bit", sig_out_bit, 0);
    chk("rst_last", sig_out_last, 0);
    @(negedge clk);
    reset = 1'b0;

    // fold = 3, step(1) = 2, 2 ^ 3 = 1
    data_in = 64'h0000_0001_0000_0002; data_valid = 1'b1;
    tick();
    chk("fold_sig", dut.sig, 32'h0000_0001);

    data_in = 64'h0000_0000_8000_0003;
    tick();
    chk("fb1_sig", dut.sig, 32'h8000_0001);
    chk("fb1_parity", sig_parity, 0);

    data_in = 64'h0;
    tick();
    chk("fb2_sig", dut.sig, 32'h04C1_1DB5);
    chk("fb2_parity", sig_parity, 1);

    // step(04C11DB5) = 09823B6A; fold chosen so the result is A5A50001
    data_in = 64'h0000_0000_AC27_3B6B;
    tick();
    chk("load_sig", dut.sig, 32'hA5A5_0001);
    chk("load_parity", sig_parity, 1);
    chk("idle_busy", busy, 0);

    // Snapshot with data_valid in the same cycle, valid held throughout.
    data_in = 64'h0; data_valid = 1'b1; snap_req = 1'b1;
    model_sig = 32'hA5A5_0001;
    tick();
    snap_req = 1'b0;
    chk("snap_sig_upd", dut.sig, model_sig);
    read_stream("s1", EXP_S1, 1'b1, 1'b1);
    data_valid = 1'b0;
    chk("s1_sig_end", dut.sig, model_sig);
    chk("s1_busy_drop", busy, 0);
    chk("s1_valid_drop", sig_out_valid, 0);
    chk("s1_bit_drop", sig_out_bit, 0);
    tick();
    chk("s1_no_second", busy, 0);
    chk("s1_no_second_v", sig_out_valid, 0);

    // Accepted the cycle after the ignored request; abort at bit 10.
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("s2_start", busy, 1);
    repeat (9) tick();
    chk("s2_bit10_busy", busy, 1);
    chk("s2_bit10_valid", sig_out_valid, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", sig_out_valid, 0);
    chk("abort_bit", sig_out_bit, 0);
    chk("abort_last", sig_out_last, 0);
    chk("abort_sig", dut.sig, 32'h0000_0001);
    chk("abort_parity", sig_parity, 1);
    @(negedge clk);
    reset = 1'b0;

    // Five zero-input valids from seed: 1 -> 2 -> 4 -> 8 -> 10 -> 20
    data_in = 64'h0; data_valid = 1'b1;
    repeat (5) tick();
    data_valid = 1'b0;
    chk("cnt_sig", dut.sig, 32'h0000_0020);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    read_stream("s3", EXP_S3, 1'b0, 1'b0);
    chk("s3_busy_drop", busy, 0);
    chk("s3_last_drop", sig_out_last, 0);
    chk("s3_sig_hold", dut.sig, 32'h0000_0020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_signature_compactor.md
# output_signature_compactor

Counterpart to the random stimulus generators on the bitstream-generation tops: it absorbs a wide DUT output bus into a multiple-input signature register (MISR), so synthesis cannot prune logic whose outputs have no pin. The signature reaches the pins in two ways: a one-pin serial readout on request, and a live parity bit. One instance sits in each `*_random` top, fed by the concatenated unused DUT outputs.

## Interface
- `WIDTH`, 64: width of the compacted input bus; must be ≥ `SIG_WIDTH`.
- `SIG_WIDTH`, 32: signature register width.
- `POLY`, `compactor_pkg::DEFAULT_POLY` (32'h04C1_1DB7): feedback taps.
- `SEED`, 32'h0000_0001: signature reset value.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `data_in`  in  `WIDTH`  DUT output bus.
- `data_valid`  in  1  accumulate `data_in` this cycle.
- `snap_req`  in  1  capture the signature and start serial readout.
- `busy`  out  1  readout in progress.
- `sig_out_bit`  out  1  serial signature bit, MSB first.
- `sig_out_valid`  out  1  `sig_out_bit` is meaningful.
- `sig_out_last`  out  1  final bit of the stream.
- `sig_parity`  out  1  XOR-reduction of the signature register.

## Operation
- Fold: split `data_in` into `SIG_WIDTH` chunks starting at the LSB, zero-pad the top chunk, XOR all chunks into `fold`.
- MISR step (Galois, shift left): `msb = sig[SIG_WIDTH-1]`; `step = {sig[SIG_WIDTH-2:0],1'b0} ^ (msb ? POLY : 0)`.
- Update: when `data_valid` is high, `sig <= step ^ fold`; otherwise `sig` holds.
- FSM states: IDLE and SHIFT.
  - IDLE with `snap_req` high: load `shadow <= sig`, using the pre-update value of that cycle. Clear `bitcnt`. Go to SHIFT.
  - SHIFT: each cycle shift `shadow` left by one and increment `bitcnt`. When `bitcnt == LEN-1`, return to IDLE.
  - `LEN` = `SIG_WIDTH`, or `SIG_WIDTH+16` with the count feature.
- `snap_req` is ignored in SHIFT; no queuing.
- MISR accumulation continues during SHIFT.
- `data_valid` and `snap_req` in the same IDLE cycle: the snapshot takes the old `sig`, and `sig` still updates.

## Timing
- Reset values:
  - `sig = SEED`, `shadow = 0`, `bitcnt = 0`, state IDLE.
  - All outputs 0, except `sig_parity = ^SEED` (1 for the default seed).
- `sig` is visible one cycle after the `data_valid` edge.
- `sig_parity` is combinational from `sig`.
- `snap_req` sampled at edge N: `sig_out_valid` and `busy` are high from N+1 through N+LEN.
- `sig_out_bit = shadow[MSB]` and is registered.
- `sig_out_last` is high only on the cycle with `bitcnt == LEN-1`.
- Back-to-back: `snap_req` on the cycle `sig_out_last` is high is ignored. It is accepted from the following cycle onward.
- Reset mid-readout aborts immediately: all outputs 0, state IDLE.

## Configuration
- `COMPACTOR_CAPTURE_COUNT_EN` defined:
  - Adds a 16-bit saturating count of accepted `data_valid` cycles; reset 0; stays at 16'hFFFF once reached.
  - The count is captured into `shadow` alongside `sig` on snapshot, in the low 16 bits.
  - The stream is `SIG_WIDTH+16` bits: signature first, then count, both MSB first.
- Undefined: no counter; the stream is exactly `SIG_WIDTH` bits.

## Structure
- `compactor_pkg` holds:
  - the `state_t` enum (IDLE, SHIFT);
  - `DEFAULT_POLY`;
  - the `COUNT_WIDTH = 16` constant.
- Sub-module `signature_shifter`: the shadow register, `bitcnt` and FSM. It is parameterised by `LEN`, and the top instantiates it once.
- Fold and MISR stay in the top.

## Test plan
- Reset → `sig = 32'h0000_0001`, `sig_parity = 1`, `busy = 0`, all other outputs 0.
- One `data_valid` with `data_in = 64'h0000_0001_0000_0002` → `fold = 3`, `sig = 32'h0000_0001`.
- Feedback check:
  - From seed, `data_in = 64'h0000_0000_8000_0003` valid → `sig = 32'h8000_0001`.
  - Then `data_in = 0` valid → `sig = 32'h04C1_1DB5`.
- Serial readout:
  - `sig = 32'hA5A5_0001`, pulse `snap_req` → 32 valid bits.
  - Bits are 1,0,1,0,0,1,0,1…, with the final bit 1.
  - `sig_out_last` is high on bit 32 only.
  - `busy` drops the following cycle.
- `snap_req` pulsed mid-readout → stream unchanged, no second stream.
  - With `data_valid` held throughout the readout, `sig` keeps updating.
- Reset asserted at readout bit 10 → outputs 0 immediately and `sig = SEED`.
  - A new `snap_req` after reset gives a clean 32-bit stream, or 48 bits with `COMPACTOR_CAPTURE_COUNT_EN`.
  - With the count feature: count 5 after five valids → trailing 16 bits are 16'h0005.
